// File: rtl/huffman_dec.sv
// huffman_dec: streaming decoder for a unary-prefix code, one codeword per cycle
module huffman_dec #(
    parameter int W = 8,
    parameter int C = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_in,
    input  logic         en_in,
    output logic         rdy_out,
    output logic [W-1:0] d_out,
    output logic [C-1:0] w_out,
    output logic [3:0]   sym_out,
    output logic         en_out,
    output logic         err_out
);
    localparam int N = $clog2(2 * W + 1);

    logic [2*W-1:0] sr, nsr;
    logic [N-1:0]   cnt, ncnt, use_n, rest;
    logic [C-1:0]   k, w;
    logic           ok, err, acc, b;

    assign rdy_out = (cnt <= N'(W)) && !rst;
    assign acc     = en_in && rdy_out;

    // leading-ones count, decode/error decision and next buffer contents
    always_comb begin
        k = C'(W - 1);
        for (int i = W - 2; i >= 0; i--)
            if (!sr[2*W-1-i]) k = C'(i);
        w     = k + C'(2);
        b     = sr[2*W-2-int'(k)];
        ok    = (int'(k) <= W - 2) && (int'(cnt) >= int'(k) + 2);
        err   = (int'(k) == W - 1) && (cnt >= N'(W));
        use_n = ok ? N'(k) + N'(2) : err ? N'(W) : '0;
        rest  = cnt - use_n;
        nsr   = (sr << use_n) | (acc ? ({d_in, {W{1'b0}}} >> rest) : '0);
        ncnt  = rest + (acc ? N'(W) : '0);
    end

    // buffer, fill count and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            cnt     <= '0;
            d_out   <= '0;
            w_out   <= '0;
            sym_out <= '0;
            en_out  <= 1'b0;
            err_out <= 1'b0;
        end else begin
            sr      <= nsr;
            cnt     <= ncnt;
            en_out  <= ok;
            err_out <= err;
            if (ok) begin
                d_out   <= sr[2*W-1:W] & ~({W{1'b1}} >> w);
                w_out   <= w;
                sym_out <= {k[2:0], b};
            end
        end
    end
endmodule

// File: tb/tb_huffman_dec.sv
// tb_huffman_dec: directed checks of the Huffman decoder
module tb_huffman_dec;
    logic       clk = 0;
    logic       rst = 1;
    logic [7:0] d_in = 0;
    logic       en_in = 0;
    logic       rdy_out;
    logic [7:0] d_out;
    logic [3:0] w_out;
    logic [3:0] sym_out;
    logic       en_out;
    logic       err_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int errs = 0;
    int qs[$], qw[$], qd[$], qc[$];

    huffman_dec dut (
        .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in), .rdy_out(rdy_out),
        .d_out(d_out), .w_out(w_out), .sym_out(sym_out), .en_out(en_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (en_out) begin
            qs.push_back(int'(sym_out));
            qw.push_back(int'(w_out));
            qd.push_back(int'(d_out));
            qc.push_back(cyc);
        end
        if (err_out) errs++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        qs.delete(); qw.delete(); qd.delete(); qc.delete();
        errs = 0;
    endtask

    task automatic send(input logic [7:0] v);
        int n;
        n = 0;
        while (!rdy_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_rdy_timeout", int'(rdy_out), 1);
        en_in = 1;
        d_in = v;
        @(negedge clk);
        en_in = 0;
    endtask

    task automatic drain();
        repeat (20) @(negedge clk);
    endtask

    task automatic chk_0x11(input string tag);
        chk({tag, "_count"}, qs.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_sym"}, qs[i], i % 2);
            chk({tag, "_w"}, qw[i], 2);
            chk({tag, "_d"}, qd[i], (i % 2) ? 8'h40 : 8'h00);
        end
        for (int i = 0; i < 3; i++) chk({tag, "_consec"}, qc[i+1] - qc[i], 1);
    endtask

    initial begin
        int acc, lo, n;
        repeat (2) @(negedge clk);
        chk("rst_rdy", int'(rdy_out), 0);
        chk("rst_en", int'(en_out), 0);
        chk("rst_err", int'(err_out), 0);
        chk("rst_d", int'(d_out), 0);
        chk("rst_w", int'(w_out), 0);
        chk("rst_sym", int'(sym_out), 0);
        rst = 0;
        #1 chk("rel_rdy", int'(rdy_out), 1);
        @(negedge clk);

        clr();
        send(8'h11);
        drain();
        chk_0x11("b11");

        clr();
        send(8'h92); send(8'h49); send(8'h24);
        drain();
        chk("b924_count", qs.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("b924_sym", qs[i], 2);
            chk("b924_w", qw[i], 3);
            chk("b924_d", qd[i], 8'h80);
        end

        clr();
        send(8'hFC); send(8'hFD);
        drain();
        chk("bfc_count", qs.size(), 2);
        chk("bfc_sym0", qs[0], 12);
        chk("bfc_sym1", qs[1], 13);
        chk("bfc_w0", qw[0], 8);
        chk("bfc_w1", qw[1], 8);
        chk("bfc_d0", qd[0], 8'hFC);
        chk("bfc_d1", qd[1], 8'hFD);

        clr();
        send(8'hFE);
        drain();
        chk("bfe_err", errs, 1);
        chk("bfe_noen", qs.size(), 0);
        send(8'h00);
        drain();
        chk("b00_count", qs.size(), 4);
        for (int i = 0; i < 4; i++) chk("b00_sym", qs[i], 0);
        chk("bfe_err_total", errs, 1);

        clr();
        acc = 0; lo = 0; n = 0;
        en_in = 1;
        d_in = 8'h00;
        while (n < 1000) begin
            if (acc == 20) break;
            if (rdy_out) acc++;
            else lo = 1;
            @(negedge clk);
            n++;
        end
        en_in = 0;
        chk("burst_accepted", acc, 20);
        chk("burst_rdy_low", lo, 1);
        drain();
        chk("burst_count", qs.size(), 80);
        n = 0;
        foreach (qs[i]) if (qs[i] != 0 || qw[i] != 2) n++;
        chk("burst_nonzero", n, 0);
        chk("burst_err", errs, 0);

        clr();
        send(8'hC0);
        rst = 1;
        #1 chk("mid_rdy_rst", int'(rdy_out), 0);
        @(negedge clk);
        chk("mid_en", int'(en_out), 0);
        chk("mid_err", int'(err_out), 0);
        rst = 0;
        #1 chk("mid_rdy_rel", int'(rdy_out), 1);
        @(negedge clk);
        drain();
        chk("mid_noen", qs.size(), 0);
        chk("mid_noerr", errs, 0);
        clr();
        send(8'h11);
        drain();
        chk_0x11("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/huffman_dec.md
HUFFMAN_DEC -- requirements
Module: huffman_dec

Interface
REQ-001 SHALL have parameter W, default 8: byte width and maximum codeword width.
REQ-002 SHALL have parameter C, default 4: width of the codeword-length field.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port d_in, input, W: packed bitstream byte, MSB = first bit in stream order.
REQ-006 SHALL have port en_in, input, 1: d_in valid; byte is accepted on an edge where en_in=1 and rdy_out=1.
REQ-007 SHALL have port rdy_out, output, 1: decoder can accept a byte this cycle.
REQ-008 SHALL have port d_out, output, W: decoded codeword, left-aligned, unused LSBs 0.
REQ-009 SHALL have port w_out, output, C: codeword length in bits, 2..8.
REQ-010 SHALL have port sym_out, output, 4: symbol index 0..13.
REQ-011 SHALL have port en_out, output, 1: one-cycle strobe qualifying d_out, w_out and sym_out.
REQ-012 SHALL have port err_out, output, 1: one-cycle strobe for an invalid codeword.

Function
REQ-013 SHALL hold a 2W-bit left-aligned bit buffer plus a fill count cnt (0..16); buffer bits are consumed from the MSB.
REQ-014 SHALL drive rdy_out = (cnt <= W) and not rst, decoded combinationally from registers.
REQ-015 SHALL append an accepted byte directly below the cnt valid bits.
REQ-016 SHALL decode the code set: k leading ones (k = 0..6), then a 0, then bit b.
- Width = k+2.
- sym_out = 2k+b.
- Examples: 00 -> 0; 01 -> 1; 100 -> 2; 11111101 -> 13.
REQ-017 SHALL decode at most one codeword per cycle, and only when the first zero lies within the cnt valid bits and cnt >= k+2.
- Otherwise wait without consuming bits.
REQ-018 SHALL treat 7 leading ones with cnt >= 8 as invalid:
- drop 8 bits;
- pulse err_out for one cycle;
- hold en_out = 0.
REQ-019 SHALL register the outputs.
- A codeword decodable on edge t asserts en_out, d_out, w_out and sym_out from edge t to edge t+1.
- d_out, w_out and sym_out hold their last values while en_out = 0.
REQ-020 SHALL support a decode and a byte acceptance on the same edge: cnt_next = cnt - width + W.
REQ-021 SHALL make the first codeword of a byte accepted at edge t appear on en_out no earlier than edge t+1.
REQ-022 SHALL sustain one codeword per cycle while bits are available, with no bubbles.
REQ-023 SHALL never drop or duplicate bits; the en_in=1, rdy_out=0 case leaves d_in unsampled.
REQ-024 SHALL give output order equal to stream order; the output stream is bit-identical to the huffman_enc input (d_in, w_in) for the same stream.
REQ-025 SHALL treat trailing zero padding as ordinary bits; framing is the consumer's responsibility.

Reset
REQ-026 SHALL, on any edge with rst=1, clear the buffer, cnt, d_out, w_out, sym_out, en_out and err_out to 0.
REQ-027 SHALL hold rdy_out = 0 while rst=1 and drive rdy_out = 1 in the first cycle after rst falls.
REQ-028 SHALL let rst mid-stream discard all buffered bits and any pending output, emitting no en_out or err_out on that edge.

Verification
REQ-029 SHALL cover: byte 0x11 -> four en_out pulses on consecutive cycles:
- sym 0,1,0,1;
- w_out = 2;
- d_out = 0x00, 0x40, 0x00, 0x40.
REQ-030 SHALL cover: bytes 0x92, 0x49, 0x24 -> eight pulses, each sym 2, w_out 3, d_out 0x80.
REQ-031 SHALL cover: bytes 0xFC, 0xFD -> sym 12, then sym 13; w_out 8; d_out 0xFC, 0xFD.
REQ-032 SHALL cover: byte 0xFE, then 0x00 -> one err_out pulse, then four sym 0 pulses; no en_out for the 0xFE.
REQ-033 SHALL cover: en_in held at 1 for 20 bytes of 0x00 -> rdy_out deasserts while cnt > 8, exactly 80 sym 0 pulses, no lost or extra symbols.
REQ-034 SHALL cover: rst pulsed after a byte 0xC0 is accepted (cnt = 8, mid-decode) -> en_out stays 0, rdy_out = 0 while rst, then 1 on release; a following byte 0x11 decodes as in REQ-029.
